thermo_mask_seq: RTL and testbench
==================================

// Module: thermo_mask_seq
// PURPOSE
//  Sequential, parametrised thermometer-mask generator for the GNN datapath.
//  Accepts a vector length and emits a stream of LANES-wide lane-valid masks.
//  Every beat except the last is all-ones. The last beat has the low (len mod LANES) bits set.
//  Sits between the feature/edge-list fetch control and the lane-parallel aggregation units.
// PARAMETERS
//  LANES  64  mask width per beat; power of two, >= 2
//  LEN_W  16  width of the requested length, in elements
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             asynchronous reset, active-high
//  s_valid     in   1             command valid
//  s_ready     out  1             command ready
//  s_len       in   LEN_W         number of valid elements in the command
//  m_valid     out  1             mask beat valid
//  m_ready     in   1             mask beat ready
//  m_mask      out  LANES         lane-valid mask; bit i = lane i
//  m_last      out  1             final beat of the command
//  m_cnt       out  CW            set bits in m_mask, CW=$clog2(LANES)+1 (TMASK_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, any cycle): state=IDLE; m_valid=0; m_mask=0; m_last=0; m_cnt=0; rem=0.
//    Reset mid-command drops the command; no further beats are emitted.
//  - States:
//    - IDLE: s_ready=1, m_valid=0.
//    - RUN: m_valid=1.
//  - Accept = s_valid & s_ready. Accept loads rem=s_len and enters RUN.
//    The first beat is registered and m_valid rises the cycle after accept (latency 1).
//  - Beat contents are computed from rem:
//    - rem >= LANES: mask = all ones; last = (rem == LANES).
//    - rem < LANES: mask = (1<<rem)-1, evaluated at LANES+1 bits; last = 1.
//    - s_len = 0: exactly one beat, mask = 0, last = 1. Every command yields >= 1 last beat.
//  - Beat handshake = m_valid & m_ready:
//    - non-last beat: rem -= LANES and the next beat is registered.
//    - last beat: return to IDLE.
//  - While m_valid & !m_ready: m_mask, m_last and m_cnt are held stable. rem does not change.
//  - Back-to-back commands: s_ready = IDLE | (m_valid & m_ready & m_last).
//    This is a combinational path from m_ready to s_ready, deliberate, to allow zero bubble.
//    - Accept in the same cycle as a last-beat handshake: rem reloads, state stays RUN,
//      and the new command's first beat is presented on the next cycle.
//  - Number of beats per command = max(1, ceil(s_len / LANES)).
//    rem never underflows because a last beat always ends the command.
//  - s_len is sampled only at accept; later changes to it are ignored.
// CONFIGURATION
//  - TMASK_CNT_EN defined:
//    - m_cnt port exists and carries min(rem, LANES) for the current beat.
//    - m_cnt is registered with the mask, held under backpressure, and reset to 0.
//  - TMASK_CNT_EN undefined: m_cnt port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package gnn_mask_pkg holds:
//    - the state enum (IDLE, RUN);
//    - the default LANES;
//    - the function/localparam for CW = $clog2(LANES)+1.
//  - Sub-module thermo_dec #(LANES): purely combinational.
//    - cnt[CW-1:0] -> mask[LANES-1:0]: low cnt bits set.
//    - cnt >= LANES gives all ones; cnt = 0 gives zero.
//    - It replaces hand-enumerated case tables and is instantiated once for the beat mask.
//  - Top level holds the FSM, the rem counter and the output registers.
// TESTING (LANES=64, LEN_W=16)
//  1. s_len=130, m_ready=1:
//     -> 3 beats: FFFF_FFFF_FFFF_FFFF, FFFF_FFFF_FFFF_FFFF, 0000_0000_0000_0003.
//     -> m_last only on beat 3; m_cnt = 64, 64, 2.
//  2. s_len=0 -> one beat, m_mask=0, m_last=1, m_cnt=0.
//     s_len=64 -> one beat, all ones, m_last=1.
//  3. s_len=50 -> one beat 0003_FFFF_FFFF_FFFF, m_last=1, m_cnt=50.
//     Also sweep s_len=0..129 and check every beat against a reference model.
//  4. s_len=200 with m_ready low for 5 cycles on beat 2:
//     -> beat 2 is held unchanged; beats continue after m_ready rises; 4 beats total, last = 0xFF.
//  5. Two commands (70, 3) with s_valid held and m_ready=1:
//     -> the second is accepted in the same cycle as the first's last beat.
//     -> beats are all-ones, 0x3F, 0x7 with no idle cycle between them.
//  6. Assert rst in the cycle after the first beat of s_len=300:
//     -> m_valid drops immediately; s_ready=1 after reset.
//     -> the next command s_len=5 yields a single beat 0x1F.

Source files
------------

// File: rtl/gnn_mask_pkg.sv
// Shared types and sizing helpers for the GNN lane-mask generator.
package gnn_mask_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_LANES = 64;

  // Width needed to hold a lane count from 0 up to and including LANES.
  function automatic int cnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/thermo_dec.sv
// Combinational thermometer decoder: the low cnt bits of mask are set,
// and cnt >= LANES saturates to all ones.
module thermo_dec
  import gnn_mask_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic [cnt_w(LANES)-1:0] cnt,
  output logic [LANES-1:0]        mask
);

  localparam int CW = cnt_w(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign mask[gi] = (cnt > CW'(gi));
  end

endmodule

// File: rtl/thermo_mask_seq.sv
// Streams LANES-wide lane-valid masks for a requested vector length.
// Define TMASK_CNT_EN to add the per-beat set-bit count output m_cnt.
module thermo_mask_seq
  import gnn_mask_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LEN_W-1:0]        s_len,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES-1:0]        m_mask,
  output logic                    m_last
`ifdef TMASK_CNT_EN
  ,
  output logic [cnt_w(LANES)-1:0] m_cnt
`endif
);

  localparam int CW = cnt_w(LANES);

  state_t             r_state;
  state_t             w_state_next;
  logic [LEN_W-1:0]   r_rem;
  logic [LANES-1:0]   r_mask;
  logic               r_last;

  logic               w_accept;
  logic               w_beat_hs;
  logic               w_load;
  logic [LEN_W-1:0]   w_src;
  logic [CW-1:0]      w_cnt;
  logic               w_last_next;
  logic [LANES-1:0]   w_mask;

  assign m_valid   = (r_state == RUN);
  assign w_beat_hs = m_valid & m_ready;
  assign w_accept  = s_valid & s_ready;

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (w_accept) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        // Zero-bubble handoff: a new command may be taken on the last-beat handshake.
        s_ready = w_beat_hs & r_last;
        if (w_accept) begin
          w_load = 1'b1;
        end else if (w_beat_hs) begin
          if (r_last) w_state_next = IDLE;
          else        w_load       = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Remaining-element count for the beat about to be registered.
  assign w_src       = w_accept ? s_len : (r_rem - LEN_W'(LANES));
  assign w_cnt       = (w_src >= LEN_W'(LANES)) ? CW'(LANES) : w_src[CW-1:0];
  assign w_last_next = (w_src <= LEN_W'(LANES));

  thermo_dec #(
    .LANES (LANES)
  ) u_dec (
    .cnt  (w_cnt),
    .mask (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_rem  <= w_src;
        r_mask <= w_mask;
        r_last <= w_last_next;
      end
    end
  end

  assign m_mask = r_mask;
  assign m_last = r_last;

`ifdef TMASK_CNT_EN
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_load) r_cnt <= w_cnt;
  end

  assign m_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_thermo_mask_seq.sv
// Directed bench for thermo_mask_seq (LANES=64, LEN_W=16); m_cnt checks
// are included when TMASK_CNT_EN is defined.
module tb_thermo_mask_seq;

  localparam int LANES = 64;
  localparam int LEN_W = 16;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] mask;
    logic        last;
    logic [7:0]  cnt;
    int          cyc;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [LEN_W-1:0] s_len = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [63:0]      m_mask;
  logic             m_last;
`ifdef TMASK_CNT_EN
  logic [6:0]       m_cnt;
`endif

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  beat_t beats[$];

  thermo_mask_seq #(
    .LANES (LANES),
    .LEN_W (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_len   (s_len),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_mask  (m_mask),
    .m_last  (m_last)
`ifdef TMASK_CNT_EN
    ,
    .m_cnt   (m_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so negedge sees the handshake about to happen.
  always @(negedge clk) begin
    beat_t b;
    if (m_valid && m_ready) begin
      b.mask = m_mask;
      b.last = m_last;
`ifdef TMASK_CNT_EN
      b.cnt  = 8'(m_cnt);
`else
      b.cnt  = 8'd0;
`endif
      b.cyc  = cyc;
      beats.push_back(b);
      $display("beat cyc=%0d mask=%h last=%0b cnt=%0d", b.cyc, b.mask, b.last, b.cnt);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return just after the edge that accepted it.
  task automatic issue(input int len);
    logic acc;
    s_valid = 1'b1;
    s_len   = LEN_W'(len);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      if (acc) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_last(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (beats.size() > 0 && beats[beats.size()-1].last) return;
      tick();
    end
    check("last_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [63:0] mask,
                            input logic last, input int cnt);
    if (idx >= beats.size()) begin
      check({tag, "_missing"}, 64'(beats.size()), 64'(idx + 1));
      return;
    end
    check({tag, "_mask"}, beats[idx].mask, mask);
    check({tag, "_last"}, 64'(beats[idx].last), 64'(last));
`ifdef TMASK_CNT_EN
    check({tag, "_cnt"}, 64'(beats[idx].cnt), 64'(cnt));
`else
    if (cnt < 0) check({tag, "_cnt"}, 64'd0, 64'd1);
`endif
  endtask

  // Expected beats of a length, from the max(1, ceil(len/64)) rule.
  task automatic check_len(input string tag, input int len);
    int nb;
    int r;
    logic [63:0] m;
    nb = (len == 0) ? 1 : (len + 63) / 64;
    check({tag, "_nbeats"}, 64'(beats.size()), 64'(nb));
    for (int k = 0; k < nb; k++) begin
      r = len - 64 * k;
      m = 64'd0;
      for (int b = 0; b < 64; b++) if (b < r) m[b] = 1'b1;
      check_beat(tag, k, m, (k == nb - 1), (r > 64) ? 64 : r);
    end
  endtask

  task automatic run_len(input string tag, input int len);
    beats.delete();
    issue(len);
    wait_last(200);
    tick();
    check_len(tag, len);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_mask", m_mask, 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
`ifdef TMASK_CNT_EN
    check("rst_m_cnt", 64'(m_cnt), 64'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_s_ready", 64'(s_ready), 64'd1);
    check("idle_m_valid", 64'(m_valid), 64'd0);

    // 1: 130 elements
    beats.delete();
    issue(130);
    wait_last(50);
    tick();
    check("t1_nbeats", 64'(beats.size()), 64'd3);
    check_beat("t1_b0", 0, ONES, 1'b0, 64);
    check_beat("t1_b1", 1, ONES, 1'b0, 64);
    check_beat("t1_b2", 2, 64'h0000_0000_0000_0003, 1'b1, 2);

    // 2: empty and exactly-one-beat lengths
    beats.delete();
    issue(0);
    wait_last(50);
    tick();
    check("t2a_nbeats", 64'(beats.size()), 64'd1);
    check_beat("t2a", 0, 64'd0, 1'b1, 0);
    beats.delete();
    issue(64);
    wait_last(50);
    tick();
    check("t2b_nbeats", 64'(beats.size()), 64'd1);
    check_beat("t2b", 0, ONES, 1'b1, 64);

    // 3: partial beat, then the sweep
    beats.delete();
    issue(50);
    wait_last(50);
    tick();
    check("t3_nbeats", 64'(beats.size()), 64'd1);
    check_beat("t3", 0, 64'h0003_FFFF_FFFF_FFFF, 1'b1, 50);
    for (int len = 0; len < 130; len++) run_len($sformatf("sweep%0d", len), len);

    // 4: backpressure on beat 2 of 200
    beats.delete();
    m_ready = 1'b0;
    issue(200);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d_valid", i), 64'(m_valid), 64'd1);
      check($sformatf("t4_hold%0d_mask", i), m_mask, ONES);
      check($sformatf("t4_hold%0d_last", i), 64'(m_last), 64'd0);
`ifdef TMASK_CNT_EN
      check($sformatf("t4_hold%0d_cnt", i), 64'(m_cnt), 64'd64);
`endif
      tick();
    end
    m_ready = 1'b1;
    wait_last(50);
    tick();
    check("t4_nbeats", 64'(beats.size()), 64'd4);
    check_beat("t4_b1", 1, ONES, 1'b0, 64);
    check_beat("t4_b3", 3, 64'h0000_0000_0000_00FF, 1'b1, 8);

    // 5: back-to-back 70 then 3 with s_valid held
    beats.delete();
    s_valid = 1'b1;
    s_len   = 16'd70;
    @(negedge clk);
    check("t5_ready_first", 64'(s_ready), 64'd1);
    tick();
    s_len = 16'd3;
    @(negedge clk);
    check("t5_ready_b0", 64'(s_ready), 64'd0);
    tick();
    @(negedge clk);
    check("t5_ready_on_last", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    wait_last(20);
    tick();
    check("t5_nbeats", 64'(beats.size()), 64'd3);
    check_beat("t5_b0", 0, ONES, 1'b0, 64);
    check_beat("t5_b1", 1, 64'h0000_0000_0000_003F, 1'b1, 6);
    check_beat("t5_b2", 2, 64'h0000_0000_0000_0007, 1'b1, 3);
    if (beats.size() == 3) begin
      check("t5_gap01", 64'(beats[1].cyc - beats[0].cyc), 64'd1);
      check("t5_gap12", 64'(beats[2].cyc - beats[1].cyc), 64'd1);
    end

    // 6: reset mid-command
    beats.delete();
    issue(300);
    tick();
    rst = 1'b1;
    #1;
    check("t6_valid_in_rst", 64'(m_valid), 64'd0);
    check("t6_mask_in_rst", m_mask, 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_ready_after", 64'(s_ready), 64'd1);
    check("t6_valid_after", 64'(m_valid), 64'd0);
    check("t6_beats_before_rst", 64'(beats.size()), 64'd1);
    beats.delete();
    issue(5);
    wait_last(20);
    tick();
    check("t6_nbeats", 64'(beats.size()), 64'd1);
    check_beat("t6_b0", 0, 64'h0000_0000_0000_001F, 1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
